rv_instr_stim_gen: RTL



---
 rtl/rv_instr_stim_gen.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rv_instr_stim_gen.sv
// rv_instr_stim_gen: LFSR-driven RISC-V instruction source that issues
// R-type / I-type / load words over valid/ready, then drains with NOPs.
module rv_instr_stim_gen #(
   parameter logic [31:0] SEED       = 32'h000002DE,
   parameter int          NUM_INSTR  = 64,
   parameter int          DRAIN_NOPS = 5,
   parameter int          CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic             instr_ready,
   output logic             instr_valid,
   output logic [31:0]      instr,
   output logic             done,
   output logic [CNT_W-1:0] issued_count
);

   localparam logic [31:0] NOP       = 32'h00000013;
   localparam logic [31:0] MASK      = 32'h80200003;
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0] DRAIN_N   = 32'(DRAIN_NOPS);
   localparam bit          HAS_DRAIN = (DRAIN_NOPS > 0);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INSTR - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      lfsr_q, lfsr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_q, mode_d;
   logic [31:0]      drain_q, drain_d;
   logic             valid_q, valid_d;
   logic             done_q, done_d;

   logic [31:0] lfsr_nxt;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3, f3_l;
   logic [11:0] imm, imm_i;
   logic [6:0]  f7;
   logic [1:0]  kind;
   logic [31:0] r_word, i_word, l_word, gen_word;

   // Right-shifting Galois step; taps applied when the bit shifted out is 1.
   assign lfsr_nxt = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? MASK : 32'd0);

   always_comb begin
      rd   = lfsr_q[4:0];
      rs1  = lfsr_q[9:5];
      rs2  = lfsr_q[14:10];
      f3   = lfsr_q[17:15];
      imm  = lfsr_q[29:18];
      f7   = ((f3 == 3'd0 || f3 == 3'd5) && lfsr_q[30]) ? 7'h20 : 7'h00;
      unique case (f3)
         3'd1:    imm_i = imm & 12'h01F;
         3'd5:    imm_i = imm & 12'h41F;
         default: imm_i = imm;
      endcase
      f3_l   = (f3 == 3'd3 || f3 >= 3'd6) ? 3'd2 : f3;
      r_word = {f7, rs2, rs1, f3, rd, 7'b0110011};
      i_word = {imm_i, rs1, f3, rd, 7'b0010011};
      l_word = {imm, rs1, f3_l, rd, 7'b0000011};
      kind   = (mode_q == 2'd3) ? lfsr_q[31:30] : mode_q;
      unique case (kind)
         2'd1:    gen_word = i_word;
         2'd2:    gen_word = l_word;
         default: gen_word = r_word;
      endcase
   end

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      drain_d = drain_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RUN;
               mode_d  = mode;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            if (instr_ready) begin
               lfsr_d = lfsr_nxt;
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST_IDX) begin
                  if (HAS_DRAIN) begin
                     state_d = S_DRAIN;
                     drain_d = DRAIN_N;
                  end else begin
                     state_d = S_DONE;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (instr_ready) begin
               drain_d = drain_q - 32'd1;
               if (drain_q == 32'd1) state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      valid_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         lfsr_q  <= SEED_EFF;
         cnt_q   <= '0;
         mode_q  <= 2'd0;
         drain_q <= 32'd0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         drain_q <= drain_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   assign instr        = (state_q == S_RUN) ? gen_word : NOP;
   assign instr_valid  = valid_q;
   assign done         = done_q;
   assign issued_count = cnt_q;

endmodule
